// File: rtl/tetris_pkg.sv
// Shared sprite geometry, pixel-code and block-style definitions for the
// block-sprite ROM interface.
package tetris_pkg;

  localparam int CELL_PX       = 16;  // sprite / cell edge in pixels
  localparam int SPRITE_ROWS   = 16;  // ROM rows per style
  localparam int BPP           = 2;   // bits per pixel in a sprite row
  localparam int SPRITE_ROW_W  = CELL_PX * BPP;
  localparam int SPRITE_ADDR_W = 6;

  typedef logic [BPP-1:0] pix_code_t;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    STYLE1 = 2'd1,
    STYLE2 = 2'd2,
    STYLE3 = 2'd3
  } block_style_t;

  // ROM address of one sprite row: styles are stacked SPRITE_ROWS apart.
  function automatic logic [SPRITE_ADDR_W-1:0] sprite_addr(block_style_t style,
                                                            logic [3:0]   row);
    return {style, row};
  endfunction

endpackage

// File: rtl/block_sprite_renderer_pixel_mux.sv
// Picks one 2-bit pixel code out of a 32-bit sprite row; column 0 is the
// most significant pair, so columns read left-to-right from the MSB.
module sprite_pixel_mux
  import tetris_pkg::*;
(
  input  logic [SPRITE_ROW_W-1:0] i_row,
  input  logic [3:0]              i_sub_x,
  output pix_code_t               o_code
);

  logic [4:0] w_lsb;

  // Low bit of the selected pair: column c sits at bits [31-2c : 30-2c].
  assign w_lsb  = 5'd30 - {i_sub_x, 1'b0};
  assign o_code = i_row[w_lsb +: 2];

endmodule

// File: rtl/block_sprite_renderer.sv
// Three-stage pixel pipeline: screen position -> board cell lookup ->
// sprite ROM row address -> 2-bit pixel code for the palette stage.
// Accepts one pixel per clock with a fixed latency of three cycles.
module block_sprite_renderer
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_X0    = 200,
  parameter int unsigned BOARD_Y0    = 80,
  parameter int unsigned BOARD_COLS  = 10,
  parameter int unsigned BOARD_ROWS  = 20,
  parameter pix_code_t   BORDER_CODE = 2'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [9:0]  PIX_X,
  input  logic [9:0]  PIX_Y,
  input  logic        PIX_VALID,
  output logic [3:0]  CELL_COL,
  output logic [4:0]  CELL_ROW,
  input  logic [1:0]  CELL_STYLE,
  output logic [5:0]  SPRITE_ADDR,
  input  logic [31:0] SPRITE_DATA,
  output logic [1:0]  PIXEL_CODE,
  output logic        PIXEL_VALID,
  output logic        IN_BOARD
);

  // Playfield bounds as 11-bit values so the right/bottom edge never wraps.
  localparam logic [10:0] X_LO = 11'(BOARD_X0);
  localparam logic [10:0] X_HI = 11'(BOARD_X0 + CELL_PX * BOARD_COLS);
  localparam logic [10:0] Y_LO = 11'(BOARD_Y0);
  localparam logic [10:0] Y_HI = 11'(BOARD_Y0 + CELL_PX * BOARD_ROWS);

  // Only the low bits of the board-relative position are consumed; the low
  // bits of a difference depend only on the low bits of its operands.
  logic [7:0] w_rel_x;
  logic [8:0] w_rel_y;
  logic       w_in_x;
  logic       w_in_y;
  pix_code_t  w_code;

  assign w_rel_x = PIX_X[7:0] - X_LO[7:0];
  assign w_rel_y = PIX_Y[8:0] - Y_LO[8:0];
  assign w_in_x  = ({1'b0, PIX_X} >= X_LO) && ({1'b0, PIX_X} < X_HI);
  assign w_in_y  = ({1'b0, PIX_Y} >= Y_LO) && ({1'b0, PIX_Y} < Y_HI);

  // Stage 1 registers
  logic [3:0] r_cell_col;
  logic [4:0] r_cell_row;
  logic [3:0] r_sub_x1;
  logic [3:0] r_sub_y1;
  logic       r_in1;
  logic       r_valid1;

  // Stage 2 registers
  logic [5:0] r_addr;
  logic [3:0] r_sub_x2;
  logic       r_in2;
  logic       r_valid2;

  // Stage 3 registers
  pix_code_t  r_code;
  logic       r_in3;
  logic       r_valid3;

  // Stage 1: split the board-relative position into cell index and offset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every stage samples the previous
    // stage's value from before this edge, giving a true shift pipeline.
    if (RESET) begin
      r_cell_col <= '0;
      r_cell_row <= '0;
      r_sub_x1   <= '0;
      r_sub_y1   <= '0;
      r_in1      <= 1'b0;
      r_valid1   <= 1'b0;
    end else begin
      r_cell_col <= w_rel_x[7:4];
      r_cell_row <= w_rel_y[8:4];
      r_sub_x1   <= w_rel_x[3:0];
      r_sub_y1   <= w_rel_y[3:0];
      r_in1      <= w_in_x && w_in_y;
      r_valid1   <= PIX_VALID;
    end
  end

  // Stage 2: combine the board store's cell style with the row inside the cell.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr   <= '0;
      r_sub_x2 <= '0;
      r_in2    <= 1'b0;
      r_valid2 <= 1'b0;
    end else begin
      r_addr   <= sprite_addr(block_style_t'(CELL_STYLE), r_sub_y1);
      r_sub_x2 <= r_sub_x1;
      r_in2    <= r_in1;
      r_valid2 <= r_valid1;
    end
  end

  sprite_pixel_mux u_pixel_mux (
    .i_row   (SPRITE_DATA),
    .i_sub_x (r_sub_x2),
    .o_code  (w_code)
  );

  // Stage 3: pick the pixel code; blanking forces every output to zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_code   <= '0;
      r_in3    <= 1'b0;
      r_valid3 <= 1'b0;
    end else begin
      if (!r_valid2) begin
        r_code <= '0;
      end else if (r_in2) begin
        r_code <= w_code;
      end else begin
        r_code <= BORDER_CODE;
      end
      r_in3    <= r_in2 && r_valid2;
      r_valid3 <= r_valid2;
    end
  end

  assign CELL_COL    = r_cell_col;
  assign CELL_ROW    = r_cell_row;
  assign SPRITE_ADDR = r_addr;
  assign PIXEL_CODE  = r_code;
  assign PIXEL_VALID = r_valid3;
  assign IN_BOARD    = r_in3;

endmodule
